// File: rtl/rram_core_ofifo_arbiter.sv
// Shares one output FIFO among NUM_CORE controller cores: per-core 2-entry skid buffers drained by a
// round-robin arbiter that tags each word with its source core. Optional counters: RRAM_OFIFO_ARB_CNT_EN.
module rram_core_ofifo_arbiter #(
  parameter int NUM_CORE      = 4,
  parameter int DATAOUT_WIDTH = 64,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                              CLK,
  input  logic                              reset_n,
  input  logic [NUM_CORE-1:0]               push_n_core,
  input  logic [NUM_CORE*DATAOUT_WIDTH-1:0] din_core,
  output logic [NUM_CORE-1:0]               full_core,
  output logic [NUM_CORE-1:0]               ovf_core,
  output logic                              push_n_oFIFO,
  output logic [DATAOUT_WIDTH-1:0]          din_oFIFO,
  output logic [$clog2(NUM_CORE)-1:0]       tag_oFIFO,
  input  logic                              full_oFIFO,
  output logic [NUM_CORE*CNT_WIDTH-1:0]     fwd_cnt
);

  localparam int TW = $clog2(NUM_CORE);
  localparam logic [TW:0] NC = (TW+1)'(NUM_CORE);

  logic [NUM_CORE-1:0][1:0]      r_cnt;
  logic [NUM_CORE-1:0]           r_full;
  logic [NUM_CORE-1:0]           r_ovf;
  logic [NUM_CORE-1:0]           r_wp;
  logic [NUM_CORE-1:0]           r_rp;
  logic [TW-1:0]                 r_last;
  logic [DATAOUT_WIDTH-1:0]      r_mem [NUM_CORE][2];

  logic [NUM_CORE-1:0]           w_valid;
  logic [NUM_CORE-1:0]           w_acc;
  logic [NUM_CORE-1:0]           w_pop;
  logic [NUM_CORE-1:0][1:0]      w_cnt_nxt;
  logic [DATAOUT_WIDTH-1:0]      w_head [NUM_CORE];
  logic                          w_any;
  logic                          w_xfer;
  logic [TW-1:0]                 w_gnt;
  logic [TW:0]                   w_idx;

  always_comb begin
    for (int i = 0; i < NUM_CORE; i++) begin
      w_valid[i] = (r_cnt[i] != 2'd0);
      w_acc[i]   = !push_n_core[i] && !r_full[i];
      w_head[i]  = r_mem[i][r_rp[i]];
    end
  end

  // Round-robin search starting just after the last granted core
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    for (int k = 1; k <= NUM_CORE; k++) begin
      w_idx = {1'b0, r_last} + (TW+1)'(k);
      if (w_idx >= NC) w_idx = w_idx - NC;
      if (!w_any && w_valid[w_idx[TW-1:0]]) begin
        w_any = 1'b1;
        w_gnt = w_idx[TW-1:0];
      end
    end
  end

  assign w_xfer = w_any && !full_oFIFO;

  always_comb begin
    for (int i = 0; i < NUM_CORE; i++) begin
      w_pop[i] = w_xfer && (w_gnt == TW'(i));
      case ({w_acc[i], w_pop[i]})
        2'b10:   w_cnt_nxt[i] = r_cnt[i] + 2'd1;
        2'b01:   w_cnt_nxt[i] = r_cnt[i] - 2'd1;
        default: w_cnt_nxt[i] = r_cnt[i];
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_full <= '0;
      r_ovf  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_last <= TW'(NUM_CORE-1);
    end else begin
      for (int i = 0; i < NUM_CORE; i++) begin
        r_cnt[i]  <= w_cnt_nxt[i];
        r_full[i] <= (w_cnt_nxt[i] == 2'd2);
        if (!push_n_core[i] && r_full[i]) r_ovf[i] <= 1'b1;
        if (w_acc[i]) r_wp[i] <= ~r_wp[i];
        if (w_pop[i]) r_rp[i] <= ~r_rp[i];
      end
      if (w_xfer) r_last <= w_gnt;
    end
  end

  // Storage carries no reset: counts and pointers alone decide what is visible
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_CORE; i++) begin
      if (w_acc[i]) r_mem[i][r_wp[i]] <= din_core[i*DATAOUT_WIDTH +: DATAOUT_WIDTH];
    end
  end

`ifdef RRAM_OFIFO_ARB_CNT_EN
  logic [NUM_CORE-1:0][CNT_WIDTH-1:0] r_fwd;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_fwd <= '0;
    end else begin
      for (int i = 0; i < NUM_CORE; i++) begin
        if (w_pop[i] && (r_fwd[i] != '1)) r_fwd[i] <= r_fwd[i] + CNT_WIDTH'(1);
      end
    end
  end

  assign fwd_cnt = r_fwd;
`else
  assign fwd_cnt = '0;
`endif

  assign full_core    = r_full;
  assign ovf_core     = r_ovf;
  assign push_n_oFIFO = !w_xfer;
  assign din_oFIFO    = w_any ? w_head[w_gnt] : '0;
  assign tag_oFIFO    = w_any ? w_gnt : '0;

endmodule

// File: tb/tb_rram_core_ofifo_arbiter.sv
// Bench for rram_core_ofifo_arbiter: table vectors, hand sequences and a queue-based reference model.
module tb_rram_core_ofifo_arbiter;

  logic          CLK = 1'b0;
  logic          reset_n;
  logic [3:0]    push_n_core;
  logic [255:0]  din_core;
  logic [3:0]    full_core;
  logic [3:0]    ovf_core;
  logic          push_n_oFIFO;
  logic [63:0]   din_oFIFO;
  logic [1:0]    tag_oFIFO;
  logic          full_oFIFO;
  logic [15:0]   fwd_cnt;

`ifdef RRAM_OFIFO_ARB_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  always #5 CLK = ~CLK;

  rram_core_ofifo_arbiter #(.NUM_CORE(4), .DATAOUT_WIDTH(64), .CNT_WIDTH(4)) dut (
    .CLK(CLK), .reset_n(reset_n), .push_n_core(push_n_core), .din_core(din_core),
    .full_core(full_core), .ovf_core(ovf_core), .push_n_oFIFO(push_n_oFIFO),
    .din_oFIFO(din_oFIFO), .tag_oFIFO(tag_oFIFO), .full_oFIFO(full_oFIFO), .fwd_cnt(fwd_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: one queue per core, last-granted index, sticky overflow, saturating counts
  logic [63:0] mq [4][$];
  int          m_last;
  logic [3:0]  m_ovf;
  int          m_fwd [4];

  function automatic int m_grant();
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (m_last + k) % 4;
      if (mq[idx].size() > 0) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      m_fwd[i] = 0;
    end
    m_ovf  = '0;
    m_last = 3;
  endtask

  task automatic model_check(input string nm);
    int          g;
    logic [3:0]  ef;
    logic [15:0] efw;
    logic [63:0] ed;
    g  = m_grant();
    ed = '0;
    if (g >= 0) ed = mq[g][0];
    for (int i = 0; i < 4; i++) begin
      ef[i] = (mq[i].size() == 2);
      efw[i*4 +: 4] = CNT_ON ? 4'(m_fwd[i]) : 4'd0;
    end
    chk({nm, ".push_n"}, 64'(push_n_oFIFO), (g >= 0 && !full_oFIFO) ? 64'd0 : 64'd1);
    chk({nm, ".din"},    din_oFIFO, ed);
    chk({nm, ".tag"},    64'(tag_oFIFO), (g >= 0) ? 64'(g) : 64'd0);
    chk({nm, ".full"},   64'(full_core), 64'(ef));
    chk({nm, ".ovf"},    64'(ovf_core), 64'(m_ovf));
    chk({nm, ".fwd"},    64'(fwd_cnt), 64'(efw));
  endtask

  task automatic tick();
    int g;
    bit fpre [4];
    @(posedge CLK);
    g = m_grant();
    for (int i = 0; i < 4; i++) fpre[i] = (mq[i].size() == 2);
    if (reset_n) begin
      if (g >= 0 && !full_oFIFO) begin
        void'(mq[g].pop_front());
        m_last = g;
        if (m_fwd[g] < 15) m_fwd[g]++;
      end
      for (int i = 0; i < 4; i++) begin
        if (!push_n_core[i]) begin
          if (fpre[i]) m_ovf[i] = 1'b1;
          else mq[i].push_back(din_core[i*64 +: 64]);
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    push_n_core = 4'hF;
    din_core    = '0;
    full_oFIFO  = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    model_check("reset");
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  pn;
    logic [63:0] d;
    logic        fo;
    logic        e_pn;
    logic [63:0] e_din;
    logic [1:0]  e_tag;
    logic [3:0]  e_full;
    logic [3:0]  e_ovf;
  } vec_t;

  vec_t        tv [9];
  logic [63:0] K, A, B, C;
  int          exp_rr;
  int          exp_next [4];
  int          seq [4];
  int          sent;
  int          rr_exp [4];

  initial begin
    K = 64'hABCD_ABCD_ABCD_ABCD;
    A = 64'hAAAA_0000_0000_000A;
    B = 64'hBBBB_0000_0000_000B;
    C = 64'hCCCC_0000_0000_000C;
    // single-core pass-through, then backpressure with overflow on core 2
    tv[0] = '{4'b1101, K,     1'b0, 1'b1, 64'd0, 2'd0, 4'b0000, 4'b0000};
    tv[1] = '{4'b1111, 64'd0, 1'b0, 1'b0, K,     2'd1, 4'b0000, 4'b0000};
    tv[2] = '{4'b1111, 64'd0, 1'b0, 1'b1, 64'd0, 2'd0, 4'b0000, 4'b0000};
    tv[3] = '{4'b1011, A,     1'b1, 1'b1, 64'd0, 2'd0, 4'b0000, 4'b0000};
    tv[4] = '{4'b1011, B,     1'b1, 1'b1, A,     2'd2, 4'b0000, 4'b0000};
    tv[5] = '{4'b1011, C,     1'b1, 1'b1, A,     2'd2, 4'b0100, 4'b0000};
    tv[6] = '{4'b1111, 64'd0, 1'b0, 1'b0, A,     2'd2, 4'b0100, 4'b0100};
    tv[7] = '{4'b1111, 64'd0, 1'b0, 1'b0, B,     2'd2, 4'b0000, 4'b0100};
    tv[8] = '{4'b1111, 64'd0, 1'b0, 1'b1, 64'd0, 2'd0, 4'b0000, 4'b0100};

    do_reset();
    for (int r = 0; r < 9; r++) begin
      push_n_core = tv[r].pn;
      din_core    = {4{tv[r].d}};
      full_oFIFO  = tv[r].fo;
      @(negedge CLK);
      chk($sformatf("vec%0d.push_n", r), 64'(push_n_oFIFO), 64'(tv[r].e_pn));
      chk($sformatf("vec%0d.din", r),    din_oFIFO, tv[r].e_din);
      chk($sformatf("vec%0d.tag", r),    64'(tag_oFIFO), 64'(tv[r].e_tag));
      chk($sformatf("vec%0d.full", r),   64'(full_core), 64'(tv[r].e_full));
      chk($sformatf("vec%0d.ovf", r),    64'(ovf_core), 64'(tv[r].e_ovf));
      if (r == 2) chk("single.fwd1", 64'(fwd_cnt[7:4]), CNT_ON ? 64'd1 : 64'd0);
      tick();
    end
    chk("bp.fwd2", 64'(fwd_cnt[11:8]), CNT_ON ? 64'd2 : 64'd0);

    // Fairness: every core pushes whenever it is not full
    do_reset();
    exp_rr = 0;
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0;
      exp_next[i] = 0;
    end
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 4; i++) begin
        push_n_core[i] = full_core[i];
        din_core[i*64 +: 64] = {44'd0, 4'(i), 16'(seq[i])};
      end
      @(negedge CLK);
      model_check("fair");
      if (!push_n_oFIFO) begin
        chk("fair.tag",  64'(tag_oFIFO), 64'(exp_rr));
        chk("fair.core", 64'(din_oFIFO[63:16]), 64'(exp_rr));
        chk("fair.nnnn", 64'(din_oFIFO[15:0]), 64'(exp_next[exp_rr]));
        exp_next[exp_rr]++;
        exp_rr = (exp_rr + 1) % 4;
      end
      tick();
      for (int i = 0; i < 4; i++) if (!push_n_core[i]) seq[i]++;
    end
    chk("fair.no_ovf", 64'(ovf_core), 64'd0);

    // Round-robin resume with only cores 0 and 3 active after core 0 was last granted
    do_reset();
    push_n_core = 4'b1110;
    din_core    = {4{64'h10}};
    @(negedge CLK);
    model_check("rr.a");
    tick();
    push_n_core = 4'b0110;
    din_core    = {64'h30, 64'h0, 64'h0, 64'h11};
    @(negedge CLK);
    model_check("rr.b");
    tick();
    rr_exp = '{3, 0, 3, 0};
    for (int c = 0; c < 4; c++) begin
      push_n_core = {full_core[3], 2'b11, full_core[0]};
      din_core    = {64'h31 + 64'(c), 64'h0, 64'h0, 64'h12 + 64'(c)};
      @(negedge CLK);
      model_check("rr.c");
      chk($sformatf("rr.grant%0d", c), 64'(tag_oFIFO), 64'(rr_exp[c]));
      tick();
    end

    // Reset pulsed between edges while two cores hold two words each
    do_reset();
    full_oFIFO  = 1'b1;
    push_n_core = 4'b1001;
    for (int c = 0; c < 2; c++) begin
      din_core = {4{64'h5000 + 64'(c)}};
      @(negedge CLK);
      model_check("mrst.fill");
      tick();
    end
    push_n_core = 4'hF;
    full_oFIFO  = 1'b0;
    #1;
    model_check("mrst.pre");
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("mrst.push_n", 64'(push_n_oFIFO), 64'd1);
    chk("mrst.full",   64'(full_core), 64'd0);
    chk("mrst.ovf",    64'(ovf_core), 64'd0);
    chk("mrst.din",    din_oFIFO, 64'd0);
    #3;
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge CLK);
      model_check("mrst.after");
    end
    tick();

    // Random traffic against the model
    for (int c = 0; c < 300; c++) begin
      push_n_core = 4'($urandom);
      for (int i = 0; i < 4; i++) din_core[i*64 +: 64] = {$urandom, $urandom};
      full_oFIFO = ($urandom_range(0, 3) == 0);
      @(negedge CLK);
      model_check("rand");
      tick();
    end

    // Counter saturation: 20 words from core 0
    do_reset();
    sent = 0;
    for (int c = 0; c < 60; c++) begin
      push_n_core = {3'b111, (sent < 20) ? full_core[0] : 1'b1};
      din_core    = {192'd0, 64'(sent)};
      @(negedge CLK);
      model_check("sat");
      tick();
      if (!push_n_core[0]) sent++;
    end
    chk("sat.fwd0", 64'(fwd_cnt[3:0]), CNT_ON ? 64'hF : 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
